// File: rtl/key_press_decoder_if.sv
// Key/event handshake bundle between a debounced key source and the press
// decoder; master drives key pulses and ack, slave presents the event register.
interface key_press_decoder_if;
  logic       key_on;
  logic       key_off;
  logic       evt_ack;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_lost;
  logic       key_held;

  modport master (
    output key_on, key_off, evt_ack,
    input  evt_valid, evt_code, evt_lost, key_held
  );

  modport slave (
    input  key_on, key_off, evt_ack,
    output evt_valid, evt_code, evt_lost, key_held
  );
endinterface

// File: rtl/key_press_decoder.sv
// Classifies debounced key presses into short / long / repeat events and
// presents them through a one-deep event register with a sticky overflow flag.
module key_press_decoder #(
  parameter int LONG_TICKS   = 50_000_000,
  parameter int REPEAT_TICKS = 10_000_000,
  parameter int CNT_WIDTH    = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  key_press_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD      = 2'd1,
    LONG_HELD = 2'd2
  } state_t;

  localparam logic [1:0] EVT_NONE   = 2'b00;
  localparam logic [1:0] EVT_SHORT  = 2'b01;
  localparam logic [1:0] EVT_LONG   = 2'b10;
  localparam logic [1:0] EVT_REPEAT = 2'b11;

  localparam logic [CNT_WIDTH-1:0] LONG_LAST   = CNT_WIDTH'(LONG_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_TICKS - 1);

  state_t               state_p0, state_nxt;
  logic [CNT_WIDTH-1:0] cnt_p0, cnt_nxt;
  logic                 gen;
  logic [1:0]           gen_code;
  logic                 evt_load, evt_drop;

  logic                 evt_vld_p1;
  logic [1:0]           evt_code_p1;
  logic                 evt_lost_p1;
  logic                 key_held_p1;

  always_comb begin
    state_nxt = state_p0;
    cnt_nxt   = cnt_p0;
    gen       = 1'b0;
    gen_code  = EVT_NONE;
    case (state_p0)
      IDLE: begin
        cnt_nxt = '0;
        if (bus.key_on && !bus.key_off) state_nxt = HELD;
      end
      HELD: begin
        if (bus.key_off) begin
          gen       = 1'b1;
          gen_code  = EVT_SHORT;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (cnt_p0 == LONG_LAST) begin
          gen       = 1'b1;
          gen_code  = EVT_LONG;
          cnt_nxt   = '0;
          state_nxt = LONG_HELD;
        end else begin
          cnt_nxt = cnt_p0 + 1'b1;
        end
      end
      LONG_HELD: begin
        // Release wins over a repeat that would fire in the same cycle.
        if (bus.key_off) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (cnt_p0 == REPEAT_LAST) begin
          gen      = 1'b1;
          gen_code = EVT_REPEAT;
          cnt_nxt  = '0;
        end else begin
          cnt_nxt = cnt_p0 + 1'b1;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign evt_load = gen && (!evt_vld_p1 || bus.evt_ack);
  assign evt_drop = gen && evt_vld_p1 && !bus.evt_ack;

  // Stage p0 -> p1: decoder state and the one-deep event register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_p0    <= IDLE;
      cnt_p0      <= '0;
      evt_vld_p1  <= 1'b0;
      evt_code_p1 <= EVT_NONE;
      evt_lost_p1 <= 1'b0;
      key_held_p1 <= 1'b0;
    end else begin
      state_p0    <= state_nxt;
      cnt_p0      <= cnt_nxt;
      key_held_p1 <= (state_nxt == HELD) || (state_nxt == LONG_HELD);
      if (evt_load) begin
        evt_vld_p1  <= 1'b1;
        evt_code_p1 <= gen_code;
      end else if (bus.evt_ack) begin
        evt_vld_p1  <= 1'b0;
        evt_code_p1 <= EVT_NONE;
      end
      if (evt_drop)         evt_lost_p1 <= 1'b1;
      else if (bus.evt_ack) evt_lost_p1 <= 1'b0;
    end
  end

  assign bus.evt_valid = evt_vld_p1;
  assign bus.evt_code  = evt_code_p1;
  assign bus.evt_lost  = evt_lost_p1;
  assign bus.key_held  = key_held_p1;

endmodule

// File: doc/key_press_decoder.md
KEY_PRESS_DECODER -- requirements
Module: key_press_decoder

Interface
REQ-001 SHALL have parameter LONG_TICKS, default 50_000_000, clk cycles a key must be held to count as a long press.
REQ-002 SHALL have parameter REPEAT_TICKS, default 10_000_000, clk cycles between repeat events while a long press is held.
REQ-003 SHALL have parameter CNT_WIDTH, default 26, hold-counter width; SHALL be large enough to hold max(LONG_TICKS, REPEAT_TICKS).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, reset; reset is asynchronous and active-high.
REQ-006 SHALL have port key_on, input, 1 bit, one-cycle debounced press pulse.
REQ-007 SHALL have port key_off, input, 1 bit, one-cycle debounced release pulse.
REQ-008 SHALL have port evt_ack, input, 1 bit, consumer accepts the current event.
REQ-009 SHALL have port evt_valid, output, 1 bit, an event is pending.
REQ-010 SHALL have port evt_code, output, 2 bits: 01 short, 10 long, 11 repeat, 00 none.
REQ-011 SHALL have port evt_lost, output, 1 bit, sticky flag: an event was dropped.
REQ-012 SHALL have port key_held, output, 1 bit, high while in HELD or LONG_HELD.

Function
REQ-013 SHALL implement states IDLE, HELD and LONG_HELD; unused encodings SHALL return to IDLE next cycle.
REQ-014 IDLE with key_on=1 and key_off=0 SHALL go to HELD and clear the hold counter to 0.
REQ-015 IDLE with key_on and key_off both high SHALL ignore both and stay in IDLE; IDLE with key_off alone SHALL be ignored.
REQ-016 HELD SHALL increment the hold counter by 1 each cycle.
REQ-017 HELD with key_off=1 SHALL generate a short event (01) and go to IDLE; key_off SHALL take priority over the long-press threshold in the same cycle.
REQ-018 HELD with the counter equal to LONG_TICKS-1 and key_off=0 SHALL generate a long event (10), clear the counter and go to LONG_HELD.
REQ-019 LONG_HELD SHALL increment the counter each cycle; at REPEAT_TICKS-1 it SHALL generate a repeat event (11) and clear the counter.
REQ-020 LONG_HELD with key_off=1 SHALL go to IDLE with no event; key_off SHALL take priority over a repeat event in the same cycle.
REQ-021 key_on in HELD or LONG_HELD SHALL be ignored and SHALL NOT restart the counter.
REQ-022 The counter SHALL never wrap; the thresholds always clear it first.
REQ-023 A generated event SHALL appear on evt_valid/evt_code on the clock edge after the triggering cycle (1-cycle latency).
REQ-024 The event register SHALL be one deep; evt_valid and evt_code SHALL hold steady until a cycle with evt_ack=1.
REQ-025 evt_ack=1 with no new event SHALL clear evt_valid and set evt_code=00 next cycle; evt_ack while evt_valid=0 SHALL have no effect.
REQ-026 A new event in the same cycle as evt_ack=1 SHALL load the new event, so evt_valid stays 1 with the new code.
REQ-027 A new event while evt_valid=1 and evt_ack=0 SHALL be dropped, the old event kept, and evt_lost set to 1.
REQ-028 evt_lost SHALL stay 1 until a cycle with evt_ack=1 clears it; if a drop and an ack coincide, evt_lost SHALL be 1 next cycle.
REQ-029 key_held SHALL be a registered decode of the state (1 in HELD or LONG_HELD).

Reset
REQ-030 Reset asserted SHALL immediately force state IDLE, counter 0, evt_valid=0, evt_code=00, evt_lost=0 and key_held=0, independent of clk.
REQ-031 Reset mid-press or with an event pending SHALL discard all state; after release, the first cycle SHALL behave as IDLE and no event SHALL be emitted for the interrupted press.

Verification (LONG_TICKS=8, REPEAT_TICKS=4)
REQ-032 Short press: key_on at cycle 0, key_off at cycle 3 -> evt_valid=1, evt_code=01 from cycle 4 until ack; key_held 1 for cycles 1-3.
REQ-033 Long and repeat: key_on at cycle 0, held through cycle 20 -> long (10) after cycle 8, then repeats (11) every 4 cycles, each acked the cycle it appears; key_off -> no further event.
REQ-034 Boundary: key_off in the same cycle the counter reaches 7 -> short event 01 only, no long event.
REQ-035 Overflow: short event left un-acked, then a second short press -> evt_code stays 01 and evt_lost=1; ack clears evt_valid and evt_lost together.
REQ-036 Ack collision: ack in the same cycle a repeat is generated -> evt_valid stays 1 with code 11, evt_lost=0.
REQ-037 Async reset: rst_n pulsed mid-LONG_HELD between clock edges -> outputs 0 before the next edge; a subsequent key_off produces no event.
